// File: rtl/mux2_vector_sequencer.sv
// mux2_vector_sequencer
//   Self-test sequencer for a 2:1 mux (c = s ? b : a). It steps the mux
//   inputs through all eight {s,a,b} combinations. Each vector is held for
//   HOLD_CYCLES cycles, and mux_c is sampled on the last cycle of each hold.
//   The sequencer then reports a pass/fail verdict, an error count and the
//   first failing vector index.
//
// Parameters
//   HOLD_CYCLES : cycles each vector is held on the mux inputs (2..255)
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   run request, honoured only in IDLE or DONE
//   mux_c     in   output of the mux under test
//   mux_a     out  mux data input a
//   mux_b     out  mux data input b
//   mux_s     out  mux select
//   busy      out  vectors are being applied
//   done      out  run finished; held until next accepted start or reset
//   pass      out  done with zero mismatches
//   err_count out  mismatching vectors in the current/last run (0..8)
//   fail_vec  out  first mismatching vector index (0 when none)
//   vec_idx   out  index of the vector currently driven
module mux2_vector_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_c,
  output logic       mux_a,
  output logic       mux_b,
  output logic       mux_s,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec,
  output logic [2:0] vec_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e     state_q;
  logic [7:0] hold_q;
  logic [2:0] vec_q;
  logic [3:0] err_q;
  logic [2:0] fail_q;
  logic       mux_a_q, mux_b_q, mux_s_q;
  logic       busy_q, done_q, pass_q;

  logic       exp_c;
  logic       sample;
  logic       mismatch;
  logic [3:0] err_d;
  logic [2:0] vec_d;

  // Expected value comes from the registered mux inputs, which have been
  // stable for the whole hold window at the sampling edge.
  always_comb begin
    exp_c    = mux_s_q ? mux_b_q : mux_a_q;
    sample   = (hold_q == HOLD_LAST);
    mismatch = sample && (mux_c != exp_c);
    err_d    = err_q + {3'b000, mismatch};
    vec_d    = vec_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      mux_a_q <= 1'b0;
      mux_b_q <= 1'b0;
      mux_s_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (sample) begin
            err_q <= err_d;
            if (mismatch && (err_q == 4'd0)) begin
              fail_q <= vec_q;
            end
            hold_q <= '0;
            if (vec_q != 3'd7) begin
              vec_q   <= vec_d;
              mux_s_q <= vec_d[2];
              mux_a_q <= vec_d[1];
              mux_b_q <= vec_d[0];
            end else begin
              // Last vector: verdict uses the count including this sample.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == 4'd0);
              mux_s_q <= 1'b0;
              mux_a_q <= 1'b0;
              mux_b_q <= 1'b0;
            end
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: begin
          // IDLE and DONE accept start identically; results are held otherwise.
          if (start) begin
            state_q <= RUN;
            hold_q  <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            mux_s_q <= 1'b0;
            mux_a_q <= 1'b0;
            mux_b_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign mux_a     = mux_a_q;
  assign mux_b     = mux_b_q;
  assign mux_s     = mux_s_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
  assign vec_idx   = vec_q;

endmodule

// File: tb/tb_mux2_vector_sequencer.sv
// Testbench for mux2_vector_sequencer: emulates good and faulty muxes and
// checks the reported results against a vector-by-vector reference model.
module tb_mux2_vector_sequencer;

  localparam int unsigned HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mux_c;
  logic       mux_a, mux_b, mux_s;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] fail_vec;
  logic [2:0] vec_idx;

  // Emulated mux: 0 good, 1 stuck-at-0, 2 inverted select, 3 random flips
  int         mode;
  logic [7:0] flip_mask;

  int checks   = 0;
  int failures = 0;

  mux2_vector_sequencer #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mux_c     (mux_c),
    .mux_a     (mux_a),
    .mux_b     (mux_b),
    .mux_s     (mux_s),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec),
    .vec_idx   (vec_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       mux_c = 1'b0;
      2:       mux_c = mux_s ? mux_a : mux_b;
      3:       mux_c = (mux_s ? mux_b : mux_a) ^ flip_mask[{mux_s, mux_a, mux_b}];
      default: mux_c = mux_s ? mux_b : mux_a;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk vectors 0..7 and compare the emulated mux against c=s?b:a.
  function automatic void model(input int m, input logic [7:0] mask,
                                output int errs, output int first);
    errs  = 0;
    first = 0;
    for (int v = 0; v < 8; v++) begin
      int s, a, b, good, c;
      s = (v >> 2) & 1;
      a = (v >> 1) & 1;
      b = v & 1;
      good = (s != 0) ? b : a;
      case (m)
        1:       c = 0;
        2:       c = (s != 0) ? a : b;
        3:       c = good ^ int'(mask[v]);
        default: c = good;
      endcase
      if (c != good) begin
        if (errs == 0) first = v;
        errs++;
      end
    end
  endfunction

  // Called on the first busy negedge; returns on the first non-busy negedge.
  task automatic wait_run(input bit poke, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      check("vec_idx", 32'(vec_idx), 32'(cycles / HOLD));
      check("mux_in", 32'({mux_s, mux_a, mux_b}), 32'(cycles / HOLD));
      if (poke) start = (cycles == 13);
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input int m, input logic [7:0] mask);
    int errs, first;
    model(m, mask, errs, first);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'(errs == 0));
    check({tag, "_err"}, 32'(err_count), 32'(errs));
    check({tag, "_fail"}, 32'(fail_vec), 32'(first));
    check({tag, "_mux0"}, 32'({mux_s, mux_a, mux_b}), 32'd0);
  endtask

  // Entered at a negedge; start is held if keep, else pulsed one cycle.
  task automatic run_check(input string tag, input int m, input logic [7:0] mask,
                           input bit poke, input bit keep);
    int cycles;
    mode      = m;
    flip_mask = mask;
    start     = 1'b1;
    @(negedge clk);
    check({tag, "_start_busy"}, 32'(busy), 32'd1);
    check({tag, "_start_done"}, 32'(done), 32'd0);
    check({tag, "_start_err"}, 32'(err_count), 32'd0);
    check({tag, "_start_fail"}, 32'(fail_vec), 32'd0);
    if (!keep) start = 1'b0;
    wait_run(poke, cycles);
    start = keep;
    check({tag, "_cycles"}, 32'(cycles), 32'(8 * HOLD));
    check_result(tag, m, mask);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    mode      = 0;
    flip_mask = '0;
    start     = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({mux_a, mux_b, mux_s, busy, done, pass, err_count, fail_vec, vec_idx}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    run_check("good", 0, 8'h00, 1'b0, 1'b0);
    run_check("poke", 0, 8'h00, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("done_held", 32'(done), 32'd1);

    run_check("stuck0", 1, 8'h00, 1'b0, 1'b0);
    check("stuck0_err_abs", 32'(err_count), 32'd4);
    check("stuck0_fail_abs", 32'(fail_vec), 32'd2);

    // Restart from DONE with start held high: back-to-back runs.
    run_check("b2b1", 0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    check("b2b_done_1cyc", 32'(done), 32'd0);
    check("b2b_rerun", 32'(busy), 32'd1);
    start = 1'b0;
    wait_run(1'b0, cycles);
    check("b2b2_cycles", 32'(cycles), 32'(8 * HOLD));
    check_result("b2b2", 0, 8'h00);

    run_check("invsel", 2, 8'h00, 1'b0, 1'b0);
    check("invsel_err_abs", 32'(err_count), 32'd4);
    check("invsel_fail_abs", 32'(fail_vec), 32'd1);

    for (int i = 0; i < 4; i++) begin
      run_check("rand", 3, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end
    run_check("allflip", 3, 8'hFF, 1'b0, 1'b0);

    // Reset during vector 5.
    mode  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (vec_idx !== 3'd5 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    check("reach_vec5", 32'(vec_idx), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs", 32'({mux_a, mux_b, mux_s, busy, done, pass, err_count, fail_vec, vec_idx}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 32'({mux_a, mux_b, mux_s, busy, done, pass, err_count, fail_vec, vec_idx}), 32'd0);
    run_check("after_rst", 0, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
